// File: rtl/mux16_1_rr.sv
// mux16_1_rr: 16-to-1 round-robin arbitrated mux with a single registered
// output stage and valid/ready handshakes on both sides.
module mux16_1_rr #(
   parameter int unsigned WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [16*WIDTH-1:0]   in_data,
   input  logic [15:0]           in_valid,
   output logic [15:0]           in_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic [3:0]            out_sel,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [15:0]           xfer_count
);

   localparam int unsigned NUM_CH = 16;
   localparam int unsigned SEL_W  = 4;

   logic [SEL_W-1:0] r_ptr;
   logic [WIDTH-1:0] r_out_data;
   logic [SEL_W-1:0] r_out_sel;
   logic             r_out_valid;
   logic [15:0]      r_xfer_count;

   logic             w_slot_free;
   logic             w_load;
   logic             w_found;
   logic [SEL_W-1:0] w_gnt_idx;
   logic [SEL_W-1:0] w_cand;
   logic [WIDTH-1:0] w_gnt_data;

   // The output register can take a new word when empty or draining this cycle
   assign w_slot_free = !r_out_valid || out_ready;
   assign w_load      = w_slot_free && (in_valid != 16'h0000);

   // First requesting channel scanning upward from the pointer, modulo 16
   always_comb begin
      w_found   = 1'b0;
      w_gnt_idx = '0;
      w_cand    = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_cand = SEL_W'(r_ptr + SEL_W'(i));
         if (!w_found && in_valid[w_cand]) begin
            w_found   = 1'b1;
            w_gnt_idx = w_cand;
         end
      end
   end

   assign w_gnt_data = in_data[int'(w_gnt_idx)*WIDTH +: WIDTH];

   // Grant is combinational; forced low during reset so nothing is consumed
   assign in_ready = (w_load && !reset) ? 16'(16'd1 << w_gnt_idx) : 16'h0000;

   // Output register, round-robin pointer and transfer counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ptr        <= '0;
         r_out_data   <= '0;
         r_out_sel    <= '0;
         r_out_valid  <= 1'b0;
         r_xfer_count <= '0;
      end else begin
         if (r_out_valid && out_ready) begin
            r_xfer_count <= r_xfer_count + 16'd1;
         end
         if (w_load) begin
            r_out_data  <= w_gnt_data;
            r_out_sel   <= w_gnt_idx;
            r_out_valid <= 1'b1;
            r_ptr       <= SEL_W'(w_gnt_idx + SEL_W'(1));
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_data   = r_out_data;
   assign out_sel    = r_out_sel;
   assign out_valid  = r_out_valid;
   assign xfer_count = r_xfer_count;

endmodule

// File: tb/tb_mux16_1_rr.sv
// tb_mux16_1_rr: directed-vector bench for the round-robin 16:1 mux.
module tb_mux16_1_rr;

   localparam int unsigned WIDTH = 16;

   logic                clk;
   logic                reset;
   logic [16*WIDTH-1:0] in_data;
   logic [15:0]         in_valid;
   logic [15:0]         in_ready;
   logic [WIDTH-1:0]    out_data;
   logic [3:0]          out_sel;
   logic                out_valid;
   logic                out_ready;
   logic [15:0]         xfer_count;

   int n_vec;
   int n_err;

   mux16_1_rr #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_sel    (out_sel),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .xfer_count (xfer_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply a reset pulse and return at a falling edge, ready to drive
   task automatic do_reset();
      @(negedge clk);
      reset    = 1'b1;
      in_valid = 16'h0000;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Load channel k with base + k
   task automatic fill_data(input logic [WIDTH-1:0] base);
      for (int k = 0; k < 16; k++) in_data[k*WIDTH +: WIDTH] = base + WIDTH'(k);
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      in_valid  = 16'hFFFF;
      out_ready = 1'b1;
      fill_data(16'h0000);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_vec++;
         if (in_ready !== 16'h0000 || out_valid !== 1'b0 || xfer_count !== 16'h0000 ||
             out_sel !== 4'h0 || out_data !== 16'h0000) begin
            $display("FAIL reset_state: in_ready=%h out_valid=%b xfer=%h sel=%h data=%h, want 0000/0/0000/0/0000",
                     in_ready, out_valid, xfer_count, out_sel, out_data);
            n_err++;
         end
      end
      reset    = 1'b0;
      in_valid = 16'h0000;
   endtask

   task automatic test_single();
      do_reset();
      fill_data(16'h0000);
      in_data[3*WIDTH +: WIDTH] = 16'hBEEF;
      in_valid  = 16'h0008;
      out_ready = 1'b1;
      #1;
      n_vec++;
      if (in_ready !== 16'h0008) begin
         $display("FAIL single_grant: in_ready=%h want 0008", in_ready);
         n_err++;
      end
      @(posedge clk); #1;
      n_vec++;
      if (out_valid !== 1'b1 || out_sel !== 4'd3 || out_data !== 16'hBEEF) begin
         $display("FAIL single_out: valid=%b sel=%0d data=%h want 1/3/beef", out_valid, out_sel, out_data);
         n_err++;
      end
      in_valid = 16'h0000;
      @(posedge clk); #1;
      n_vec++;
      if (out_valid !== 1'b0 || out_data !== 16'hBEEF || out_sel !== 4'd3 || xfer_count !== 16'd1) begin
         $display("FAIL single_drain: valid=%b data=%h sel=%0d xfer=%0d want 0/beef/3/1",
                  out_valid, out_data, out_sel, xfer_count);
         n_err++;
      end
      // Idle cycles must not move the pointer: channel 3 and 4 both request, 4 wins
      @(posedge clk); @(negedge clk);
      in_valid = 16'h0018;
      #1;
      n_vec++;
      if (in_ready !== 16'h0010) begin
         $display("FAIL idle_ptr_hold: in_ready=%h want 0010", in_ready);
         n_err++;
      end
      @(negedge clk);
      in_valid = 16'h0000;
   endtask

   task automatic test_full_scan();
      do_reset();
      fill_data(16'h0000);
      in_valid  = 16'hFFFF;
      out_ready = 1'b1;
      for (int k = 0; k <= 16; k++) begin
         #1;
         n_vec++;
         if (in_ready !== 16'(16'd1 << (k % 16))) begin
            $display("FAIL scan_grant[%0d]: in_ready=%h want %h", k, in_ready, 16'(16'd1 << (k % 16)));
            n_err++;
         end
         @(posedge clk); #1;
         n_vec++;
         if (out_valid !== 1'b1 || out_sel !== 4'(k % 16) || out_data !== 16'(k % 16) ||
             xfer_count !== 16'(k)) begin
            $display("FAIL scan_out[%0d]: valid=%b sel=%0d data=%h xfer=%0d want 1/%0d/%0h/%0d",
                     k, out_valid, out_sel, out_data, xfer_count, k % 16, k % 16, k);
            n_err++;
         end
         @(negedge clk);
      end
      in_valid = 16'h0000;
   endtask

   task automatic test_backpressure();
      do_reset();
      fill_data(16'h0100);
      in_valid  = 16'hFFFF;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 16'h00F0;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_vec++;
         if (in_ready !== 16'h0000) begin
            $display("FAIL bp_ready[%0d]: in_ready=%h want 0000", c, in_ready);
            n_err++;
         end
         @(posedge clk); #1;
         n_vec++;
         if (out_valid !== 1'b1 || out_sel !== 4'd0 || out_data !== 16'h0100 || xfer_count !== 16'd0) begin
            $display("FAIL bp_hold[%0d]: valid=%b sel=%0d data=%h xfer=%0d want 1/0/0100/0",
                     c, out_valid, out_sel, out_data, xfer_count);
            n_err++;
         end
         @(negedge clk);
         in_valid = (c == 1) ? 16'h0003 : 16'hFFFF;
      end
      out_ready = 1'b1;
      in_valid  = 16'hFFFF;
      #1;
      n_vec++;
      if (in_ready !== 16'h0002) begin
         $display("FAIL bp_release_grant: in_ready=%h want 0002", in_ready);
         n_err++;
      end
      @(posedge clk); #1;
      n_vec++;
      if (out_valid !== 1'b1 || out_sel !== 4'd1 || out_data !== 16'h0101 || xfer_count !== 16'd1) begin
         $display("FAIL bp_release_out: valid=%b sel=%0d data=%h xfer=%0d want 1/1/0101/1",
                  out_valid, out_sel, out_data, xfer_count);
         n_err++;
      end
      @(negedge clk);
      in_valid = 16'h0000;
      @(posedge clk); #1;
      n_vec++;
      if (out_valid !== 1'b0 || xfer_count !== 16'd2) begin
         $display("FAIL bp_drain: valid=%b xfer=%0d want 0/2", out_valid, xfer_count);
         n_err++;
      end
   endtask

   task automatic test_wrap();
      logic [15:0] exp_rdy [3];
      logic [3:0]  exp_sel [3];
      exp_rdy[0] = 16'h8000; exp_rdy[1] = 16'h0001; exp_rdy[2] = 16'h8000;
      exp_sel[0] = 4'd15;    exp_sel[1] = 4'd0;     exp_sel[2] = 4'd15;
      do_reset();
      fill_data(16'h0A00);
      out_ready = 1'b1;
      in_valid  = 16'h4000;
      @(negedge clk);
      in_valid = 16'h8001;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_vec++;
         if (in_ready !== exp_rdy[c]) begin
            $display("FAIL wrap_grant[%0d]: in_ready=%h want %h", c, in_ready, exp_rdy[c]);
            n_err++;
         end
         @(posedge clk); #1;
         n_vec++;
         if (out_sel !== exp_sel[c] || out_data !== (16'h0A00 + 16'(exp_sel[c]))) begin
            $display("FAIL wrap_out[%0d]: sel=%0d data=%h want %0d/%h",
                     c, out_sel, out_data, exp_sel[c], 16'h0A00 + 16'(exp_sel[c]));
            n_err++;
         end
         @(negedge clk);
      end
      in_valid = 16'h0000;
   endtask

   task automatic test_reset_mid();
      do_reset();
      fill_data(16'h0200);
      in_valid  = 16'hFFFF;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 16'h0020;
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 16'hFFFF;
      @(posedge clk);
      #2;
      reset     = 1'b1;
      out_ready = 1'b1;
      #1;
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 16'h0000 || xfer_count !== 16'd0 || out_sel !== 4'd0) begin
         $display("FAIL async_reset: valid=%b in_ready=%h xfer=%0d sel=%0d want 0/0000/0/0",
                  out_valid, in_ready, xfer_count, out_sel);
         n_err++;
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_vec++;
      if (in_ready !== 16'h0001) begin
         $display("FAIL post_reset_grant: in_ready=%h want 0001", in_ready);
         n_err++;
      end
      @(posedge clk); #1;
      n_vec++;
      if (out_valid !== 1'b1 || out_sel !== 4'd0 || out_data !== 16'h0200) begin
         $display("FAIL post_reset_out: valid=%b sel=%0d data=%h want 1/0/0200", out_valid, out_sel, out_data);
         n_err++;
      end
      @(negedge clk);
      in_valid = 16'h0000;
   endtask

   initial begin
      n_vec     = 0;
      n_err     = 0;
      reset     = 1'b1;
      in_valid  = 16'h0000;
      in_data   = '0;
      out_ready = 1'b0;
      test_reset();
      test_single();
      test_full_scan();
      test_backpressure();
      test_wrap();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
